// File: rtl/inst_encoder.sv
// Packs decoded field bundles into 32-bit S/I/B instruction words and streams
// them into instruction memory under a start/count load FSM.
module inst_encoder #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_type,
    input  logic [3:0]        in_opcode,
    input  logic [4:0]        in_src1,
    input  logic [4:0]        in_src2,
    input  logic [4:0]        in_dest,
    input  logic [4:0]        in_cond,
    input  logic [15:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word;
    logic              accept;
    logic              legal;

    // Only the fields of the selected format are placed; everything else stays zero.
    always_comb begin
        word      = '0;
        word[1:0] = in_type;
        word[5:2] = in_opcode;
        case (in_type)
            2'b01: begin
                word[10:6]  = in_src1;
                word[15:11] = in_src2;
                word[20:16] = in_dest;
            end
            2'b10: begin
                word[10:6]  = in_src1;
                word[15:11] = in_dest;
                word[31:16] = in_imm;
            end
            2'b11: begin
                word[10:6]  = in_dest;
                word[15:11] = in_cond;
                word[31:16] = in_imm;
            end
            default: ;
        endcase
    end

    assign accept = in_valid && (state_q == RUN);
    assign legal  = (in_type != 2'b00);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = count;
                    err_d   = 1'b0;
                    state_d = (count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (legal) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = word;
                        addr_d  = addr_q + 1'b1;
                        rem_d   = rem_q - 1'b1;
                        if (rem_q == CNT_W'(1)) begin
                            state_d = DONE;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready   = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: expected writes go into a scoreboard queue
// as bundles are driven and are popped whenever imem_we is observed.
module tb_inst_encoder;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_type;
    logic [3:0]        in_opcode;
    logic [4:0]        in_src1, in_src2, in_dest, in_cond;
    logic [15:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy, done, err;

    inst_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_opcode(in_opcode), .in_src1(in_src1), .in_src2(in_src2),
        .in_dest(in_dest), .in_cond(in_cond), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t               sb[$];
    int                passed = 0;
    int                total  = 0;
    int                writes = 0;
    logic [ADDR_W-1:0] addr_m;

    function automatic logic [31:0] enc(input logic [1:0] t, input logic [3:0] op,
                                        input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [4:0] d, input logic [4:0] c,
                                        input logic [15:0] imm);
        case (t)
            2'b01:   return {11'b0, d, s2, s1, op, t};
            2'b10:   return {imm, d, s1, op, t};
            2'b11:   return {imm, c, d, op, t};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        check({tag, ".imem_we"}, 32'(imem_we), 32'd0);
        check({tag, ".imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, ".imem_wdata"}, imem_wdata, 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".err"}, 32'(err), 32'd0);
    endtask

    // Advance one cycle, sample #1 after the edge, and score any write seen.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (imem_we === 1'b1) begin
            writes++;
            if (sb.size() == 0) begin
                check("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", imem_wdata, e.data);
            end
        end
    endtask

    task automatic start_run(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c);
        start     = 1'b1;
        base_addr = b;
        count     = c;
        addr_m    = b;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] t, input logic [3:0] op, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] d, input logic [4:0] c,
                        input logic [15:0] imm, input bit expect_write);
        in_valid  = 1'b1;
        in_type   = t;
        in_opcode = op;
        in_src1   = s1;
        in_src2   = s2;
        in_dest   = d;
        in_cond   = c;
        in_imm    = imm;
        if (expect_write && t != 2'b00) begin
            sb.push_back('{addr: addr_m, data: enc(t, op, s1, s2, d, c, imm)});
            addr_m = addr_m + 1'b1;
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int w0;
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
        in_type = '0; in_opcode = '0; in_src1 = '0; in_src2 = '0;
        in_dest = '0; in_cond = '0; in_imm = '0; addr_m = '0;
        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // S-type single word; done coincides with the write
        w0 = writes;
        start_run(10'h010, 11'd1);
        check("s.busy", 32'(busy), 32'd1);
        check("s.in_ready", 32'(in_ready), 32'd1);
        check("s.golden", enc(2'b01, 4'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'hFFFF), 32'h0003104D);
        send(2'b01, 4'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'hFFFF, 1'b1);
        check("s.we", 32'(imem_we), 32'd1);
        check("s.done", 32'(done), 32'd1);
        check("s.busy_low", 32'(busy), 32'd0);
        tick();
        check("s.done_one_cycle", 32'(done), 32'd0);
        check("s.writes", 32'(writes - w0), 32'd1);

        // I then B back to back
        w0 = writes;
        start_run(10'h020, 11'd2);
        send(2'b10, 4'd1, 5'd5, 5'd0, 5'd7, 5'd0, 16'hBEEF, 1'b1);
        check("ib.we1", 32'(imem_we), 32'd1);
        send(2'b11, 4'd0, 5'd31, 5'd0, 5'd9, 5'd4, 16'hFFFC, 1'b1);
        check("ib.we2", 32'(imem_we), 32'd1);
        check("ib.done", 32'(done), 32'd1);
        tick();
        check("ib.writes", 32'(writes - w0), 32'd2);

        // Illegal type dropped, err sticky until next start
        w0 = writes;
        start_run(10'h100, 11'd2);
        send(2'b01, 4'd2, 5'd4, 5'd6, 5'd8, 5'd0, 16'h0, 1'b1);
        send(2'b00, 4'd15, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 1'b0);
        check("ill.err", 32'(err), 32'd1);
        check("ill.no_we", 32'(imem_we), 32'd0);
        check("ill.busy", 32'(busy), 32'd1);
        send(2'b10, 4'd9, 5'd1, 5'd0, 5'd2, 5'd0, 16'h1234, 1'b1);
        check("ill.done", 32'(done), 32'd1);
        tick(); tick();
        check("ill.err_idle", 32'(err), 32'd1);
        check("ill.writes", 32'(writes - w0), 32'd2);

        // Wrap with in_valid toggling
        w0 = writes;
        start_run(10'h3FF, 11'd3);
        check("wrap.err_cleared", 32'(err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            send(2'b11, 4'(i), 5'd0, 5'd0, 5'(i + 1), 5'(i + 2), 16'(16'hA000 + i), 1'b1);
            check("wrap.we", 32'(imem_we), 32'd1);
            if (i < 2) begin
                tick();
                check("wrap.gap_no_we", 32'(imem_we), 32'd0);
            end
        end
        check("wrap.done", 32'(done), 32'd1);
        tick();
        check("wrap.writes", 32'(writes - w0), 32'd3);

        // Zero count
        w0 = writes;
        start_run(10'h050, 11'd0);
        check("zero.done", 32'(done), 32'd1);
        check("zero.busy", 32'(busy), 32'd0);
        tick();
        check("zero.done_low", 32'(done), 32'd0);
        check("zero.writes", 32'(writes - w0), 32'd0);

        // start during RUN must not relatch base/count
        w0 = writes;
        start_run(10'h060, 11'd2);
        start = 1'b1; base_addr = 10'h200; count = 11'd5;
        send(2'b01, 4'd5, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0, 1'b1);
        send(2'b01, 4'd6, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 1'b1);
        start = 1'b0;
        check("ign.done", 32'(done), 32'd1);
        tick();
        check("ign.writes", 32'(writes - w0), 32'd2);

        // Reset mid-run discards the in-flight write
        w0 = writes;
        start_run(10'h080, 11'd4);
        send(2'b10, 4'd1, 5'd1, 5'd0, 5'd1, 5'd0, 16'h1111, 1'b1);
        rst = 1'b1;
        send(2'b10, 4'd2, 5'd2, 5'd0, 5'd2, 5'd0, 16'h2222, 1'b0);
        check_reset_outputs("rstrun");
        rst = 1'b0;
        tick(); tick(); tick();
        check("rstrun.writes", 32'(writes - w0), 32'd1);
        start_run(10'h000, 11'd1);
        send(2'b01, 4'd7, 5'd9, 5'd10, 5'd11, 5'd0, 16'h0, 1'b1);
        check("rstrun.new_done", 32'(done), 32'd1);
        tick();

        check("sb.empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Builds 32-bit EyeArch instruction words from decoded field bundles and streams them into instruction memory. It is the inverse of the decode-side field extraction: it packs type, opcode, register, condition and immediate fields into the S/I/B formats. It sits between the program-load source (debug/boot loader) and the imem write port. A start/count FSM drives the write address and reports completion and format errors.

## Interface
Parameters:
- ADDR_W, 10, imem word-address width
- CNT_W, 11, width of the beat counter (must be ≥ ADDR_W+1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load run; sampled only in IDLE
- base_addr  in  ADDR_W  first imem word address of the run, latched on start
- count  in  CNT_W  number of words to write, latched on start
- in_valid  in  1  field bundle valid
- in_ready  out  1  block accepts a bundle this cycle
- in_type  in  2  01 S, 10 I, 11 B, 00 illegal
- in_opcode  in  4  opcode
- in_src1, in_src2, in_dest, in_cond  in  5 each  register/condition fields
- in_imm  in  16  immediate
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded word
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of run
- err  out  1  sticky: an illegal-type bundle was seen in the current run

## Operation
- Word layout: [1:0] type, [5:2] opcode, then per type:
  - S: [10:6] src1, [15:11] src2, [20:16] dest, [31:21] = 0
  - I: [10:6] src1, [15:11] dest, [31:16] imm
  - B: [10:6] dest (also the src2 register), [15:11] cond, [31:16] imm
- Fields unused by a format are ignored. They never leak into the word.
- FSM states are IDLE, RUN and DONE.
  - IDLE: if start is high, latch base_addr into the address counter and count into the remaining counter, and clear err. Go to DONE if count==0, otherwise go to RUN.
  - RUN: in_ready = 1. On in_valid & in_ready with a legal type, register the encoded word and address, increment the address and decrement remaining. When remaining reaches 0, go to DONE.
  - Illegal type (00) in RUN: the bundle is accepted and dropped. err is set. No write occurs, and the address and remaining counters do not change.
  - DONE: done = 1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored.
- The address counter wraps modulo 2^ADDR_W (e.g. 0x3FF → 0x000 for ADDR_W=10).
- err stays set through DONE and IDLE and clears only on the next accepted start or on rst.

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, err 0.
- Output registers:
  - imem_we/addr/wdata are registered. A bundle accepted in cycle N produces imem_we=1 in cycle N+1, with the address used at acceptance.
  - imem_we is high for exactly one cycle per legal accepted bundle.
- Throughput is one bundle per cycle in RUN.
- in_ready is combinational from state only (RUN). It does not depend on in_valid.
- The final accept in cycle N sets state to DONE at N+1, the same cycle as its imem_we. done is high at N+1 and busy is low at N+1.
- With count==0: start at cycle N gives done at N+1 and no writes.
- busy = (state == RUN).
- rst during RUN: the next cycle has all outputs at reset values. A write that was registered but not yet presented is discarded.

## Test plan
- S-type: start with base 0x010, count 1; send type 01, opcode 3, src1 1, src2 2, dest 3, imm 0xFFFF → one imem_we at addr 0x010 with data 0x0003104D; done pulses in that same cycle.
- I-type and B-type back-to-back: base 0x020, count 2; send I (opcode 1, src1 5, dest 7, imm 0xBEEF) then B (opcode 0, dest 9, cond 4, imm 0xFFFC, src1 31) → 0xBEEF3946 at 0x020, then 0xFFFC2243 at 0x021, in consecutive cycles.
- Illegal type: count 2; send type 00 between two legal bundles → exactly two writes at base and base+1; err=1 after the 00 beat and still 1 in IDLE; the next start clears it.
- Wrap and backpressure: base 0x3FF, count 3, in_valid toggling 1/0 → writes at 0x3FF, 0x000, 0x001; no write in cycles where in_valid=0.
- Zero count and ignored start: count 0 → done one cycle after start, no imem_we; a start pulse asserted during RUN does not relatch base/count.
- Reset mid-run: rst asserted after the 1st of 4 accepts → no further imem_we; all outputs at reset values next cycle; a new run then behaves normally.
